// File: rtl/augment_pkg.sv
// Shared types and defaults for the image augmentation pipeline stages.
package augment_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    BLUR_IDLE,
    BLUR_FILL,
    BLUR_FILTER,
    BLUR_DONE
  } blur_state_e;

  // Kernel weights sum to 16; add half an LSB before dropping the fraction.
  function automatic pixel_t blur_round(input logic [11:0] sum);
    logic [11:0] rounded;
    rounded = (sum + 12'd8) >> 4;
    return rounded[7:0];
  endfunction

endpackage

// File: rtl/gaussian_blur_stream_if.sv
// Pixel stream in from the crop stage, filtered stream and status out to the BRAM writer.
interface gaussian_blur_stream_if;
  import augment_pkg::*;

  pixel_t pixel_i;
  logic   pixel_valid_i;
  pixel_t pixel_o;
  logic   pixel_valid;
  logic   image_done;
  logic   busy;
  logic   dropped;

  modport master (
    output pixel_i, pixel_valid_i,
    input  pixel_o, pixel_valid, image_done, busy, dropped
  );

  modport slave (
    input  pixel_i, pixel_valid_i,
    output pixel_o, pixel_valid, image_done, busy, dropped
  );

endinterface

// File: rtl/blur_window_3x3.sv
// 3x3 Gaussian window: two registered columns plus the live column, kernel sum and rounding.
module blur_window_3x3
  import augment_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   shift,
  input  logic   load_dup,
  input  pixel_t col_top,
  input  pixel_t col_mid,
  input  pixel_t col_bot,
  output pixel_t pix
);

  pixel_t [2:0] left_q;
  pixel_t [2:0] ctr_q;
  pixel_t [2:0] col_new;
  logic   [9:0] cs_left, cs_ctr, cs_right;
  logic  [11:0] sum;

  function automatic logic [9:0] col_weight(input pixel_t [2:0] c);
    return {2'b00, c[0]} + {1'b0, c[1], 1'b0} + {2'b00, c[2]};
  endfunction

  assign col_new = {col_bot, col_mid, col_top};

  // The right-hand column is the live buffer read, so an output is ready in the shift cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q <= '0;
      ctr_q  <= '0;
    end else if (shift) begin
      left_q <= load_dup ? col_new : ctr_q;
      ctr_q  <= col_new;
    end
  end

  always_comb begin
    cs_left  = col_weight(left_q);
    cs_ctr   = col_weight(ctr_q);
    cs_right = col_weight(col_new);
    sum      = {2'b00, cs_left} + {1'b0, cs_ctr, 1'b0} + {2'b00, cs_right};
    pix      = blur_round(sum);
  end

endmodule

// File: rtl/gaussian_blur_stream.sv
// Frame-buffered 3x3 Gaussian blur: captures one image, then replays it filtered in raster order.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   BLUR_IDLE   | waiting for the first pixel of an image
//   BLUR_FILL   | writing incoming pixels into the frame buffer
//   BLUR_FILTER | WIDTH+1 column steps per row, emitting WIDTH pixels per row
//   BLUR_DONE   | one cycle; image_done follows, then back to idle
module gaussian_blur_stream
  import augment_pkg::*;
#(
  parameter int WIDTH  = IMG_W,
  parameter int HEIGHT = IMG_H
) (
  input  logic                   clk,
  input  logic                   reset,
  gaussian_blur_stream_if.slave  bus
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int RW   = $clog2(HEIGHT);

  localparam logic [AW-1:0] LAST_PIX  = AW'(NPIX - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);

  blur_state_e   state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] step_q, step_d;
  logic          wr_en, shift, load_dup, emit, drop_evt;

  pixel_t        mem [NPIX];
  logic [CW-1:0] col_rd;
  logic [RW-1:0] row_up, row_dn;
  pixel_t        rd_top, rd_mid, rd_bot, win_pix;

  pixel_t        pixel_o_q;
  logic          pixel_valid_q, image_done_q, busy_q, dropped_q;

  function automatic logic [AW-1:0] pix_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(WIDTH) + AW'(c);
  endfunction

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    row_d    = row_q;
    step_d   = step_q;
    wr_en    = 1'b0;
    shift    = 1'b0;
    load_dup = 1'b0;
    emit     = 1'b0;
    drop_evt = 1'b0;
    unique case (state_q)
      BLUR_IDLE: begin
        if (bus.pixel_valid_i) begin
          wr_en    = 1'b1;
          wr_cnt_d = AW'(1);
          state_d  = BLUR_FILL;
        end
      end
      BLUR_FILL: begin
        if (bus.pixel_valid_i) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_PIX) begin
            wr_cnt_d = '0;
            row_d    = '0;
            step_d   = '0;
            state_d  = BLUR_FILTER;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      BLUR_FILTER: begin
        shift    = 1'b1;
        load_dup = (step_q == '0);
        emit     = (step_q != '0);
        drop_evt = bus.pixel_valid_i;
        if (step_q == LAST_STEP) begin
          step_d = '0;
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = BLUR_DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      BLUR_DONE: begin
        drop_evt = bus.pixel_valid_i;
        state_d  = BLUR_IDLE;
      end
      default: state_d = BLUR_IDLE;
    endcase
  end

  // Border replication: the final step re-reads the last column, rows clamp at the edges.
  always_comb begin
    col_rd = (step_q > LAST_COL) ? LAST_COL : step_q;
    row_up = (row_q == '0) ? '0 : row_q - RW'(1);
    row_dn = (row_q == LAST_ROW) ? LAST_ROW : row_q + RW'(1);
    rd_top = mem[pix_addr(row_up, col_rd)];
    rd_mid = mem[pix_addr(row_q, col_rd)];
    rd_bot = mem[pix_addr(row_dn, col_rd)];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt_q] <= bus.pixel_i;
    end
  end

  blur_window_3x3 u_window (
    .clk      (clk),
    .reset    (reset),
    .shift    (shift),
    .load_dup (load_dup),
    .col_top  (rd_top),
    .col_mid  (rd_mid),
    .col_bot  (rd_bot),
    .pix      (win_pix)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BLUR_IDLE;
      wr_cnt_q      <= '0;
      row_q         <= '0;
      step_q        <= '0;
      pixel_o_q     <= '0;
      pixel_valid_q <= 1'b0;
      image_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      row_q         <= row_d;
      step_q        <= step_d;
      pixel_valid_q <= emit;
      if (emit) begin
        pixel_o_q <= win_pix;
      end
      image_done_q  <= (state_q == BLUR_DONE);
      // Held through DONE so busy drops on the same edge image_done rises.
      busy_q        <= (state_d != BLUR_IDLE);
      dropped_q     <= dropped_q | drop_evt;
    end
  end

  assign bus.pixel_o     = pixel_o_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.image_done  = image_done_q;
  assign bus.busy        = busy_q;
  assign bus.dropped     = dropped_q;

endmodule

// File: doc/gaussian_blur_stream.md
# gaussian_blur_stream

Streaming 3x3 Gaussian-blur augmentation stage on the 8-bit grayscale pixel stream from the crop stage, placed between the crop stage's pixel output and the packing BRAM writer. It captures one full image into an internal frame buffer, then replays it filtered in raster order on the same `pixel_o`/`pixel_valid` interface the writer already consumes. Edges are handled by border replication.

## Interface
- `WIDTH`, 28: image width in pixels.
- `HEIGHT`, 28: image height in pixels.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pixel_i`  in  8  input pixel, raster order.
- `pixel_valid_i`  in  1  `pixel_i` valid this cycle; no back-pressure.
- `pixel_o`  out  8  filtered pixel.
- `pixel_valid`  out  1  `pixel_o` valid this cycle.
- `image_done`  out  1  one-cycle pulse after the last filtered pixel.
- `busy`  out  1  high in FILL and FILTER.
- `dropped`  out  1  sticky: input pixel arrived during FILTER and was discarded.

## Operation
- Kernel [1 2 1; 2 4 2; 1 2 1]. Result = (sum + 8) >> 4. Sum is 12 bits (max 4080), result 8 bits, no saturation needed.
- Border: neighbour coordinates clamp to [0, HEIGHT-1] and [0, WIDTH-1].
- States:
  - IDLE: first `pixel_valid_i` is written to buffer[0] and moves to FILL.
  - FILL: each valid pixel is written at the write counter. The pixel at index WIDTH*HEIGHT-1 moves to FILTER.
  - FILTER: for each output row r, run WIDTH+1 column steps k=0..WIDTH.
    - Step k reads column min(k, WIDTH-1) at rows clamp(r-1), r, clamp(r+1) and shifts it into a 3-column window.
    - Step 0 loads the column into both the left and centre positions.
    - Steps 1..WIDTH each emit output (r, k-1).
    - After step WIDTH of row HEIGHT-1, go to DONE.
  - DONE: assert `image_done` for one cycle, then return to IDLE.
- Input in IDLE/FILL is always accepted. Input in FILTER/DONE is discarded and sets `dropped`.
- `dropped` clears only on reset. A new image may start the cycle after DONE.
- Reset mid-operation: return to IDLE; clear all counters, the window and all outputs. Buffer contents need not be cleared.

## Timing
- Reset values: `pixel_o`=0, `pixel_valid`=0, `image_done`=0, `busy`=0, `dropped`=0.
- Outputs are registered.
- Frame buffer read is combinational, or registered with the window delayed one stage; either way the output timing below is fixed.
- FILL has no timeout; gaps between input pixels are allowed.
- FILTER lasts HEIGHT*(WIDTH+1) cycles: 812 at 28x28.
- Output rate:
  - WIDTH consecutive valid cycles per row, then one idle cycle before the next row.
  - Exactly WIDTH*HEIGHT valid outputs per image.
- First `pixel_valid` rises 2 cycles after the cycle carrying the last input pixel.
- `image_done` is high the cycle after the final `pixel_valid`, and never coincident with it.
- `busy` rises the cycle after the first input pixel and falls with `image_done`.

## Structure
- Shared package `augment_pkg`: `IMG_W`/`IMG_H` defaults, `pixel_t` (logic [7:0]), blur state enum.
- Sub-module `blur_window_3x3` (a natural split):
  - contains the 3x3 window shift register with the step-0 duplicate load, the kernel adder tree and rounding;
  - takes a 3-pixel column and a shift strobe as input;
  - gives one pixel out.
- Top level holds the FSM, fill/row/column counters, the frame buffer (WIDTH*HEIGHT bytes, inferred RAM or register array) and clamp logic.

## Test plan
- Constant image, all pixels 100, back-to-back input → 784 outputs all equal 100.
  - First `pixel_valid` 2 cycles after the last input.
  - `image_done` at cycle 812 after FILTER entry.
- Single 255 at (5,5), rest 0 → (5,5)=64, (5,6)=32, (4,5)=32, (4,4)=16, (3,5)=0.
- Single 255 at corner (0,0) → (0,0)=143, (0,1)=48, (1,1)=16.
- Input with random 0–3-cycle gaps → output identical to the gap-free case.
  - 28 valid / 1 idle row pattern.
- 10 extra pixels during FILTER → `dropped`=1 and output unchanged.
  - Next image after DONE processes correctly.
- `reset` asserted at FILTER row 10 → outputs 0 immediately, state IDLE.
  - Full image afterwards → correct 784-pixel result.
